bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin bus arbiter placed directly upstream of the bus decoder in the interconnect. It accepts transfer requests from `NumofMaster` masters and grants the shared bus to one master at a time. It forwards the granted master's address, write data and write enable to the decoder and slaves, and returns a per-master acknowledge or timeout error. A watchdog terminates transfers that a slave never completes, so the bus cannot lock up.

## Interface
- `DWidth`, 32, address/data width; matches the decoder's `addr_i`.
- `NumofMaster`, 2, number of requesting masters (≥2).
- `TimeoutCycles`, 16, BUSY cycles without `ready_i` before forced termination (≥2).
- `MIdxWidth` (localparam), `$clog2(NumofMaster)`.
- `clk_i`  in  1  clock; all state is updated on the rising edge.
- `rst_ni`  in  1  reset: asynchronous, active-low.
- `req_i[0:NumofMaster-1]`  in  1 each  transfer request; held high with its payload until `ack_o` or `err_o`.
- `addr_i[0:NumofMaster-1]`  in  DWidth  master addresses.
- `wdata_i[0:NumofMaster-1]`  in  DWidth  master write data.
- `we_i[0:NumofMaster-1]`  in  1  master write enables.
- `ready_i`  in  1  completion from the selected slave, as returned through the decoder's response mux.
- `gnt_o[0:NumofMaster-1]`  out  1 each  one-hot grant, registered.
- `valid_o`  out  1  bus carries a live transfer.
- `addr_o`  out  DWidth  granted address; drives the decoder's `addr_i`.
- `wdata_o`  out  DWidth  granted write data.
- `we_o`  out  1  granted write enable.
- `ack_o[0:NumofMaster-1]`  out  1  completion pulse to the owning master.
- `err_o[0:NumofMaster-1]`  out  1  timeout pulse to the owning master.
- `owner_o`  out  MIdxWidth  index of the current owner, for debug and response routing.

## Operation
- FSM states:
  - IDLE: no grant. `valid_o`=0, `addr_o`/`wdata_o`/`we_o`=0.
  - BUSY: exactly one `gnt_o` bit high. Bus outputs are a combinational mux of the owner's inputs. `valid_o`=1.
- Arbitration rules:
  - Scan starts at `last+1` and wraps modulo `NumofMaster`; the first master with `req_i` high wins.
  - `last` resets to `NumofMaster-1`, so master 0 wins the first contention.
- IDLE to BUSY: if any `req_i` is high, register the winner as owner, set `last` to the winner, and clear the watchdog.
- Completion in BUSY:
  - When `ready_i`=1, `ack_o[owner]`=1 in the same cycle.
  - The next arbitration excludes the completing master for that cycle.
  - If another request is pending, its winner becomes owner on the next edge (stay BUSY, back-to-back transfer). Otherwise go to IDLE.
- Watchdog behaviour:
  - Counts BUSY cycles with `ready_i`=0; width is `$clog2(TimeoutCycles+1)`.
  - If the count equals `TimeoutCycles-1` and `ready_i`=0, assert `err_o[owner]`=1 and treat the cycle as a completion with the same exclusion rule.
  - `ready_i` and timeout in the same cycle: `ready_i` wins, giving `ack_o` and no `err_o`.
- A master that drops `req_i` while owning the bus violates protocol. The arbiter does not abort the transfer; it completes only on `ready_i` or timeout.
- Reset mid-transfer: all outputs clear asynchronously. The FSM goes to IDLE, `last` returns to `NumofMaster-1`, and no `ack_o`/`err_o` is issued for the aborted transfer.

## Timing
- Reset values:
  - Zero: `gnt_o`, `valid_o`, `addr_o`, `wdata_o`, `we_o`, `ack_o`, `err_o`, `owner_o`.
  - FSM in IDLE; `last`=`NumofMaster-1`.
- Grant latency: `req_i` sampled high in IDLE at edge N produces `gnt_o`/`valid_o` high after edge N (1 cycle).
- `ack_o`/`err_o` are combinational from `ready_i`/watchdog and last exactly one cycle.
- Back-to-back transfers: the new owner's `gnt_o` is high in the cycle right after the ack, with no idle bubble.
- Minimum transfer occupancy is 1 BUSY cycle, when `ready_i` is already high.

## Structure
- Shared package `pkg_bus` holds:
  - `arb_state_e` (IDLE, BUSY).
  - Default `TimeoutCycles`.
- Sub-module `bus_rr_picker` (combinational): inputs are the request vector, `last`, and an exclude index/enable. Outputs are `found` and the winner index.

## Test plan
- Single master: `req_i[0]`=1 with `addr_i[0]`=0x0000_0010 and `ready_i` high 2 cycles after grant → `gnt_o[0]` one cycle after the request, `addr_o`=0x10, `ack_o[0]` pulses once, then IDLE.
- Contention from reset: `req_i[0]` and `req_i[1]` both high → master 0 is granted first. On its ack, master 1 is granted in the next cycle with no bubble.
- Fairness: both masters requesting continuously for 6 transfers, `ready_i`=1 every BUSY cycle → grants alternate 0,1,0,1,0,1.
- Timeout: owner 1, `ready_i` held 0, `TimeoutCycles`=16 → `err_o[1]` pulses on the 16th BUSY cycle, no `ack_o`, bus released.
- Ready on the timeout cycle: `ready_i` first rises on the 16th BUSY cycle → `ack_o` pulses and `err_o` stays 0.
- Reset mid-transfer: `rst_ni` low during BUSY → all outputs 0 immediately. After release, master 0 has priority again.

Source files
------------

// File: rtl/pkg_bus.sv
// Shared types and defaults for the bus arbiter slice.
package pkg_bus;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DefTimeoutCycles = 16;

endpackage

// File: rtl/bus_rr_picker.sv
// Combinational round-robin picker: scans from last+1 with wrap, optionally
// skipping one excluded index, and reports the first requester found.
module bus_rr_picker #(
  parameter int NumofMaster = 2,
  localparam int MIdxWidth = $clog2(NumofMaster)
) (
  input  logic [NumofMaster-1:0] req_i,
  input  logic [MIdxWidth-1:0]   last_i,
  input  logic [MIdxWidth-1:0]   excl_idx_i,
  input  logic                   excl_en_i,
  output logic                   found_o,
  output logic [MIdxWidth-1:0]   idx_o
);

  logic [MIdxWidth-1:0]   w_cand [NumofMaster];
  logic [NumofMaster-1:0] w_elig;

  // Slot gi holds the master visited (gi+1) steps after last, so slot 0 has top priority.
  genvar gi;
  generate
    for (gi = 0; gi < NumofMaster; gi++) begin : g_cand
      assign w_cand[gi] = MIdxWidth'((int'(last_i) + gi + 1) % NumofMaster);
      assign w_elig[gi] = req_i[w_cand[gi]] && !(excl_en_i && (w_cand[gi] == excl_idx_i));
    end
  endgenerate

  always_comb begin
    found_o = |w_elig;
    idx_o   = '0;
    for (int i = NumofMaster - 1; i >= 0; i--) begin
      if (w_elig[i]) idx_o = w_cand[i];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with per-transfer watchdog; forwards the owner's
// request payload to the decoder and routes ack/timeout back to the owner.
module bus_arbiter
  import pkg_bus::*;
#(
  parameter int DWidth        = 32,
  parameter int NumofMaster   = 2,
  parameter int TimeoutCycles = DefTimeoutCycles,
  localparam int MIdxWidth    = $clog2(NumofMaster)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i   [0:NumofMaster-1],
  input  logic [DWidth-1:0]    addr_i  [0:NumofMaster-1],
  input  logic [DWidth-1:0]    wdata_i [0:NumofMaster-1],
  input  logic                 we_i    [0:NumofMaster-1],
  input  logic                 ready_i,
  output logic                 gnt_o   [0:NumofMaster-1],
  output logic                 valid_o,
  output logic [DWidth-1:0]    addr_o,
  output logic [DWidth-1:0]    wdata_o,
  output logic                 we_o,
  output logic                 ack_o   [0:NumofMaster-1],
  output logic                 err_o   [0:NumofMaster-1],
  output logic [MIdxWidth-1:0] owner_o
);

  localparam int WdWidth = $clog2(TimeoutCycles + 1);
  localparam logic [WdWidth-1:0]   WdLast   = WdWidth'(TimeoutCycles - 1);
  localparam logic [MIdxWidth-1:0] LastInit = MIdxWidth'(NumofMaster - 1);

  arb_state_e             r_state, w_state_next;
  logic [MIdxWidth-1:0]   r_owner, w_owner_next;
  logic [MIdxWidth-1:0]   r_last, w_last_next;
  logic [WdWidth-1:0]     r_wdog, w_wdog_next;
  logic [NumofMaster-1:0] r_gnt, w_gnt_next;

  logic [NumofMaster-1:0] w_req;
  logic [NumofMaster-1:0] w_win_onehot;
  logic [MIdxWidth-1:0]   w_win;
  logic                   w_found;
  logic                   w_busy;
  logic                   w_timeout;
  logic                   w_done;

  assign w_busy    = (r_state == BUSY);
  // A ready in the final watchdog cycle still counts as a normal completion.
  assign w_timeout = w_busy && !ready_i && (r_wdog == WdLast);
  assign w_done    = w_busy && (ready_i || w_timeout);

  bus_rr_picker #(
    .NumofMaster(NumofMaster)
  ) u_picker (
    .req_i     (w_req),
    .last_i    (r_last),
    .excl_idx_i(r_owner),
    .excl_en_i (w_done),
    .found_o   (w_found),
    .idx_o     (w_win)
  );

  assign w_win_onehot = {{(NumofMaster-1){1'b0}}, 1'b1} << w_win;

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    w_wdog_next  = r_wdog;
    w_gnt_next   = r_gnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next = BUSY;
          w_owner_next = w_win;
          w_last_next  = w_win;
          w_wdog_next  = '0;
          w_gnt_next   = w_win_onehot;
        end
      end
      BUSY: begin
        if (w_done) begin
          if (w_found) begin
            w_owner_next = w_win;
            w_last_next  = w_win;
            w_wdog_next  = '0;
            w_gnt_next   = w_win_onehot;
          end else begin
            w_state_next = IDLE;
            w_owner_next = '0;
            w_wdog_next  = '0;
            w_gnt_next   = '0;
          end
        end else begin
          w_wdog_next = r_wdog + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= LastInit;
      r_wdog  <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
      r_wdog  <= w_wdog_next;
      r_gnt   <= w_gnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumofMaster; gi++) begin : g_port
      assign w_req[gi] = req_i[gi];
      assign gnt_o[gi] = r_gnt[gi];
      assign ack_o[gi] = w_busy && ready_i && (r_owner == MIdxWidth'(gi));
      assign err_o[gi] = w_timeout && (r_owner == MIdxWidth'(gi));
    end
  endgenerate

  assign valid_o = w_busy;
  assign owner_o = r_owner;
  assign addr_o  = w_busy ? addr_i[r_owner]  : '0;
  assign wdata_o = w_busy ? wdata_i[r_owner] : '0;
  assign we_o    = w_busy ? we_i[r_owner]    : 1'b0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (2 masters, 16-cycle watchdog).
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req   [0:1];
  logic [31:0] addr  [0:1];
  logic [31:0] wdata [0:1];
  logic        we    [0:1];
  logic        ready;
  logic        gnt   [0:1];
  logic        ack   [0:1];
  logic        err   [0:1];
  logic        valid;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        we_o;
  logic [0:0]  owner;

  int n_cmp = 0;
  int n_bad = 0;

  wire [1:0] gnt_v = {gnt[1], gnt[0]};
  wire [1:0] ack_v = {ack[1], ack[0]};
  wire [1:0] err_v = {err[1], err[0]};

  always #5 clk = ~clk;

  bus_arbiter #(
    .DWidth(32),
    .NumofMaster(2),
    .TimeoutCycles(16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .req_i  (req),
    .addr_i (addr),
    .wdata_i(wdata),
    .we_i   (we),
    .ready_i(ready),
    .gnt_o  (gnt),
    .valid_o(valid),
    .addr_o (addr_o),
    .wdata_o(wdata_o),
    .we_o   (we_o),
    .ack_o  (ack),
    .err_o  (err),
    .owner_o(owner)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    #3;
    n_cmp++;
    if ({valid, gnt_v, ack_v, err_v, owner, we_o} !== 8'b0 || addr_o !== 32'h0 || wdata_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b gnt=%b ack=%b err=%b owner=%b we=%b addr=%h wdata=%h want all 0",
               valid, gnt_v, ack_v, err_v, owner, we_o, addr_o, wdata_o);
    end
    tick();
    tick();
    rst_ni = 1'b1;
    $display("test_reset: outputs checked during reset");
  endtask

  task automatic test_single;
    req[0] = 1'b1; addr[0] = 32'h0000_0010; wdata[0] = 32'hA5A5_0001; we[0] = 1'b1;
    #1;
    n_cmp++;
    if (gnt_v !== 2'b00 || valid !== 1'b0) begin
      n_bad++; $display("FAIL single_latency: got gnt=%b valid=%b want gnt=00 valid=0", gnt_v, valid);
    end
    tick();
    #1;
    n_cmp++;
    if (gnt_v !== 2'b01 || valid !== 1'b1 || addr_o !== 32'h10 || wdata_o !== 32'hA5A5_0001 || we_o !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: got gnt=%b valid=%b addr=%h wdata=%h we=%b want gnt=01 valid=1 addr=00000010 wdata=a5a50001 we=1",
               gnt_v, valid, addr_o, wdata_o, we_o);
    end
    tick();
    #1;
    n_cmp++;
    if (ack_v !== 2'b00 || gnt_v !== 2'b01) begin
      n_bad++; $display("FAIL single_wait: got ack=%b gnt=%b want ack=00 gnt=01", ack_v, gnt_v);
    end
    tick();
    ready = 1'b1;
    #1;
    n_cmp++;
    if (ack_v !== 2'b01 || err_v !== 2'b00) begin
      n_bad++; $display("FAIL single_ack: got ack=%b err=%b want ack=01 err=00", ack_v, err_v);
    end
    tick();
    req[0] = 1'b0; ready = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || gnt_v !== 2'b00 || ack_v !== 2'b00 || addr_o !== 32'h0) begin
      n_bad++; $display("FAIL single_idle: got valid=%b gnt=%b ack=%b addr=%h want 0/00/00/0", valid, gnt_v, ack_v, addr_o);
    end
    $display("test_single: master 0 write to 0x10 acknowledged");
  endtask

  task automatic test_contention;
    do_reset();
    req[0] = 1'b1; req[1] = 1'b1;
    addr[0] = 32'h0000_1000; addr[1] = 32'h0000_2000;
    tick();
    #1;
    n_cmp++;
    if (gnt_v !== 2'b01 || owner !== 1'b0 || addr_o !== 32'h1000) begin
      n_bad++; $display("FAIL contend_first: got gnt=%b owner=%b addr=%h want gnt=01 owner=0 addr=00001000", gnt_v, owner, addr_o);
    end
    ready = 1'b1;
    #1;
    n_cmp++;
    if (ack_v !== 2'b01) begin
      n_bad++; $display("FAIL contend_ack0: got ack=%b want 01", ack_v);
    end
    tick();
    req[0] = 1'b0; ready = 1'b0;
    #1;
    n_cmp++;
    if (gnt_v !== 2'b10 || valid !== 1'b1 || owner !== 1'b1 || addr_o !== 32'h2000) begin
      n_bad++; $display("FAIL contend_b2b: got gnt=%b valid=%b owner=%b addr=%h want gnt=10 valid=1 owner=1 addr=00002000",
                        gnt_v, valid, owner, addr_o);
    end
    ready = 1'b1;
    #1;
    n_cmp++;
    if (ack_v !== 2'b10) begin
      n_bad++; $display("FAIL contend_ack1: got ack=%b want 10", ack_v);
    end
    tick();
    req[1] = 1'b0; ready = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || gnt_v !== 2'b00) begin
      n_bad++; $display("FAIL contend_idle: got valid=%b gnt=%b want 0/00", valid, gnt_v);
    end
    $display("test_contention: grants 0 then 1 with no bubble");
  endtask

  task automatic test_fairness;
    logic [1:0] exp_g;
    req[0] = 1'b1; req[1] = 1'b1; ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if (gnt_v !== exp_g || ack_v !== exp_g) begin
        n_bad++; $display("FAIL fair_xfer%0d: got gnt=%b ack=%b want gnt=%b ack=%b", k, gnt_v, ack_v, exp_g, exp_g);
      end
      $display("test_fairness: transfer %0d granted gnt=%b", k, gnt_v);
      if (k == 5) begin
        req[0] = 1'b0; req[1] = 1'b0;
      end
    end
    tick();
    ready = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL fair_idle: got valid=%b want 0", valid);
    end
  endtask

  task automatic test_timeout;
    req[1] = 1'b1; ready = 1'b0;
    tick();
    for (int c = 1; c <= 16; c++) begin
      #1;
      n_cmp++;
      if (c < 16) begin
        if (err_v !== 2'b00 || ack_v !== 2'b00 || gnt_v !== 2'b10) begin
          n_bad++; $display("FAIL timeout_wait%0d: got err=%b ack=%b gnt=%b want 00/00/10", c, err_v, ack_v, gnt_v);
        end
      end else begin
        if (err_v !== 2'b10 || ack_v !== 2'b00) begin
          n_bad++; $display("FAIL timeout_err: got err=%b ack=%b want err=10 ack=00", err_v, ack_v);
        end
        req[1] = 1'b0;
      end
      tick();
    end
    #1;
    n_cmp++;
    if (valid !== 1'b0 || err_v !== 2'b00 || gnt_v !== 2'b00) begin
      n_bad++; $display("FAIL timeout_release: got valid=%b err=%b gnt=%b want 0/00/00", valid, err_v, gnt_v);
    end
    $display("test_timeout: master 1 terminated on BUSY cycle 16");
  endtask

  task automatic test_ready_on_timeout;
    req[0] = 1'b1; ready = 1'b0;
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (c == 16) ready = 1'b1;
      #1;
      n_cmp++;
      if (c < 16) begin
        if (err_v !== 2'b00 || ack_v !== 2'b00 || gnt_v !== 2'b01) begin
          n_bad++; $display("FAIL rdyto_wait%0d: got err=%b ack=%b gnt=%b want 00/00/01", c, err_v, ack_v, gnt_v);
        end
      end else begin
        if (ack_v !== 2'b01 || err_v !== 2'b00) begin
          n_bad++; $display("FAIL rdyto_ack: got ack=%b err=%b want ack=01 err=00", ack_v, err_v);
        end
        req[0] = 1'b0;
      end
      tick();
    end
    ready = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL rdyto_idle: got valid=%b want 0", valid);
    end
    $display("test_ready_on_timeout: ack wins over watchdog");
  endtask

  task automatic test_reset_mid;
    req[0] = 1'b1; addr[0] = 32'h0000_3000;
    tick();
    #1;
    n_cmp++;
    if (gnt_v !== 2'b01 || valid !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_setup: got gnt=%b valid=%b want 01/1", gnt_v, valid);
    end
    ready = 1'b1;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({valid, gnt_v, ack_v, err_v, owner, we_o} !== 8'b0 || addr_o !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_clear: got valid=%b gnt=%b ack=%b err=%b owner=%b we=%b addr=%h want all 0",
                        valid, gnt_v, ack_v, err_v, owner, we_o, addr_o);
    end
    #1;
    ready = 1'b0; req[1] = 1'b1;
    rst_ni = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (gnt_v !== 2'b01 || owner !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_priority: got gnt=%b owner=%b want gnt=01 owner=0", gnt_v, owner);
    end
    $display("test_reset_mid: outputs cleared, master 0 regains priority");
  endtask

  initial begin
    rst_ni = 1'b0; ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = '0; wdata[i] = '0; we[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_ready_on_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no completion within 200000 time units, want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
